// File: rtl/maxi030_bus_pkg.sv
// Shared types and region tables for the MAXI030 bus termination logic.
package maxi030_bus_pkg;

   typedef enum logic [2:0] {
      REG_NONE     = 3'd0,
      REG_ROM      = 3'd1,
      REG_SIMM     = 3'd2,
      REG_EXP      = 3'd3,
      REG_QUART    = 3'd4,
      REG_IDE      = 3'd5,
      REG_ETH      = 3'd6,
      REG_INTERNAL = 3'd7
   } region_e;

   // Encodings are the raw DSACK1:DSACK0 levels driven to the CPU.
   typedef enum logic [1:0] {
      PW_32   = 2'b00,
      PW_16   = 2'b01,
      PW_8    = 2'b10,
      PW_NONE = 2'b11
   } port_width_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK,
      ST_BERR,
      ST_RELEASE
   } state_e;

   localparam int WAIT_W = 3;

   // Wait states per region, index 7 first.
   localparam logic [7:0][WAIT_W-1:0] WAIT_TABLE = {
      3'd0,  // INTERNAL
      3'd2,  // ETH
      3'd3,  // IDE
      3'd0,  // QUART (paced by DTACK instead)
      3'd2,  // EXP
      3'd2,  // SIMM
      3'd4,  // ROM
      3'd0   // NONE
   };

   // Port width per region, index 7 first.
   localparam logic [7:0][1:0] WIDTH_TABLE = {
      PW_32,    // INTERNAL
      PW_16,    // ETH
      PW_16,    // IDE
      PW_8,     // QUART
      PW_16,    // EXP
      PW_32,    // SIMM
      PW_16,    // ROM
      PW_NONE   // NONE
   };

   function automatic port_width_e region_dsack(input region_e r);
      return port_width_e'(WIDTH_TABLE[r]);
   endfunction

   function automatic logic [WAIT_W-1:0] region_waits(input region_e r);
      return WAIT_TABLE[r];
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for one asynchronous, active-low strobe.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] pipe;

   // Shift the raw level through the chain; idle (high) out of reset.
   always_ff @(posedge clock) begin
      if (reset) pipe <= '1;
      else       pipe <= (pipe << 1) | STAGES'(d);
   end

   assign q = pipe[STAGES-1];

endmodule

// File: rtl/bus_terminator.sv
// 68030 bus-cycle termination: DSACK with dynamic sizing after per-region
// waits, or BERR on unmapped access, expansion error or timeout.
module bus_terminator
   import maxi030_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       n_as,
   input  logic [2:0] region,
   input  logic       n_waite,
   input  logic       n_berre,
   input  logic       n_quart_dtack,
   output logic [1:0] n_dsack,
   output logic       n_berr,
   output logic       cycle_active
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   // Lane order: 0 AS, 1 WAITE, 2 BERRE, 3 QUART_DTACK.
   logic [3:0] raw_vec, sync_vec;
   logic       as_s, waite_s, berre_s, dtack_s;

   assign raw_vec = {n_quart_dtack, n_berre, n_waite, n_as};

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync [3:0] (
      .clock (clock),
      .reset (reset),
      .d     (raw_vec),
      .q     (sync_vec)
   );

   assign as_s    = sync_vec[0];
   assign waite_s = sync_vec[1];
   assign berre_s = sync_vec[2];
   assign dtack_s = sync_vec[3];

   state_e            state, state_nxt;
   region_e           region_q, region_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic [TO_W-1:0]   to_cnt, to_nxt;
   logic              ready;

   // Next-state and counter logic. An aborted cycle (AS gone while waiting)
   // wins over everything so no termination is driven to an idle bus.
   always_comb begin
      state_nxt  = state;
      region_nxt = region_q;
      wait_nxt   = wait_cnt;
      to_nxt     = to_cnt;
      ready      = (wait_cnt == '0)
                && ((region_q != REG_EXP)   || waite_s)
                && ((region_q != REG_QUART) || !dtack_s);
      case (state)
         ST_IDLE: begin
            if (!as_s) begin
               if (region_e'(region) == REG_NONE) begin
                  state_nxt = ST_BERR;
               end else begin
                  region_nxt = region_e'(region);
                  wait_nxt   = region_waits(region_e'(region));
                  to_nxt     = '0;
                  state_nxt  = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (wait_cnt != '0) wait_nxt = wait_cnt - WAIT_W'(1);
            to_nxt = to_cnt + TO_W'(1);
            if (as_s)                                    state_nxt = ST_IDLE;
            else if ((region_q == REG_EXP) && !berre_s)  state_nxt = ST_BERR;
            else if (ready)                              state_nxt = ST_ACK;
            else if (to_cnt == TO_LAST)                  state_nxt = ST_BERR;
         end
         ST_ACK, ST_BERR: begin
            if (as_s) state_nxt = ST_RELEASE;
         end
         ST_RELEASE: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // State, latched region and counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         region_q <= REG_NONE;
         wait_cnt <= '0;
         to_cnt   <= '0;
      end else begin
         state    <= state_nxt;
         region_q <= region_nxt;
         wait_cnt <= wait_nxt;
         to_cnt   <= to_nxt;
      end
   end

   // Outputs registered from the next state so they switch with the state.
   always_ff @(posedge clock) begin
      if (reset) begin
         n_dsack      <= PW_NONE;
         n_berr       <= 1'b1;
         cycle_active <= 1'b0;
      end else begin
         n_dsack      <= (state_nxt == ST_ACK) ? region_dsack(region_nxt) : PW_NONE;
         n_berr       <= (state_nxt != ST_BERR);
         cycle_active <= (state_nxt != ST_IDLE);
      end
   end

endmodule

// File: doc/bus_terminator.md
# bus_terminator

Bus-cycle termination stage for the MAXI030 68030 glue logic. It sits directly downstream of the address decoder and consumes the decoded region code for every CPU cycle. It produces the 68030 termination handshake: `n_dsack` with dynamic port size after a per-region wait count, or `n_berr` on unmapped access, expansion bus error or timeout. Terminations are held until the CPU negates `n_as`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: WAIT-state cycles before a forced bus error (1..1023).
- `SYNC_STAGES`, 2: synchroniser depth for asynchronous inputs.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `n_as`  in  1  CPU address strobe, asynchronous, active low.
- `region`  in  3  decoded region for the current address; valid while `n_as` is low.
- `n_waite`  in  1  expansion wait request, asynchronous, active low.
- `n_berre`  in  1  expansion bus error, asynchronous, active low.
- `n_quart_dtack`  in  1  QUART data acknowledge, asynchronous, active low.
- `n_dsack`  out  2  CPU DSACK1:DSACK0. 00 = 32-bit, 01 = 16-bit, 10 = 8-bit, 11 = not asserted.
- `n_berr`  out  1  CPU bus error, active low.
- `cycle_active`  out  1  high in every state except IDLE.

## Operation
- Region table (constants in package): 0 NONE (unmapped); 1 ROM 16-bit, 4 waits; 2 SIMM 32-bit, 2 waits; 3 EXP 16-bit, 2 waits, honours `n_waite`/`n_berre`; 4 QUART 8-bit, 0 waits, ends on `n_quart_dtack`; 5 IDE 16-bit, 3 waits; 6 ETH 16-bit, 2 waits; 7 INTERNAL 32-bit, 0 waits.
- `n_as`, `n_waite`, `n_berre` and `n_quart_dtack` pass through `SYNC_STAGES` flops. `region` is sampled without synchronisation at the IDLE exit edge, since it is stable by then.
- States: IDLE, WAIT, ACK, BERR, RELEASE.
- IDLE: on synced AS asserted:
  - region NONE → BERR.
  - otherwise latch region, load wait counter with table value, clear timeout counter → WAIT.
- WAIT:
  - Wait counter decrements to 0 and holds; timeout counter increments.
  - Ready condition: counter == 0, and for EXP synced `n_waite` high, and for QUART synced `n_quart_dtack` low.
  - Ready → ACK.
  - EXP with synced `n_berre` low → BERR. This takes priority over ready.
  - Timeout counter == `TIMEOUT_CYCLES`−1 without ready → BERR. Ready takes priority over timeout in the same cycle.
  - Synced AS negated (CPU aborted) → IDLE.
- ACK: `n_dsack` = width code of the latched region. Held until synced AS negates → RELEASE.
- BERR: `n_berr` = 0, `n_dsack` = 11. Held until synced AS negates → RELEASE.
- RELEASE: all terminations negated for one cycle → IDLE. This guarantees the strobes are high before the next cycle is accepted, even for back-to-back AS.
- Counter widths: wait counter 3 bits; timeout counter $clog2(`TIMEOUT_CYCLES`+1) bits, no wrap because the state exits at terminal count.

## Timing
- Reset values: `n_dsack` = 11, `n_berr` = 1, `cycle_active` = 0, state IDLE, counters 0. Reset asserted mid-cycle aborts at the next edge with the same values.
- All outputs are registered and decoded from state. There are no combinational input-to-output paths.
- AS detect latency: `SYNC_STAGES` clocks from the `n_as` fall to the IDLE exit edge.
- For wait count N with no external hold: `n_dsack` asserts N+1 clocks after the IDLE exit edge. INTERNAL asserts after 1 clock.
- Release: the termination negates `SYNC_STAGES` clocks after `n_as` rises. `cycle_active` falls one clock after that.
- Timeout: `n_berr` asserts `TIMEOUT_CYCLES` clocks after entering WAIT.

## Structure
- Package `maxi030_bus_pkg`:
  - region enum (3-bit), port-width enum carrying DSACK codes.
  - state enum.
  - constant wait table and width table indexed by region.
  - function `region_dsack(region)`.
- Sub-module `sync_ff` (parameter `STAGES`, reset value 1). Four instances: AS, WAITE, BERRE, QUART_DTACK.

## Test plan
- INTERNAL (region 7), `n_as` low → `n_dsack` = 00 at detect+1; `n_as` high → 11 after 2 clocks, then RELEASE, then IDLE.
- ROM (region 1) → `n_dsack` = 01 exactly 5 clocks after the IDLE exit edge; `cycle_active` high throughout.
- EXP (region 3) with `n_waite` low for 10 clocks → `n_dsack` held 11 until 2 clocks after `n_waite` rises, then 01. Repeat with `n_berre` low and `n_waite` high on the same clock → `n_berr` = 0, `n_dsack` = 11.
- QUART (region 4) with `n_quart_dtack` never asserted, `TIMEOUT_CYCLES` = 16 → `n_berr` = 0 exactly 16 clocks after entering WAIT. Repeat with dtack arriving on the timeout clock → `n_dsack` = 10, no `n_berr`.
- Region 0 → `n_berr` = 0 one clock after detect. `reset` pulsed during BERR → `n_berr` = 1 and IDLE at the next edge.
- Back-to-back cycles with `n_as` high for 1 clock → one termination per cycle; outputs 11/1 for at least one clock between them.
